// File: rtl/dvbc_deinterleaver.sv
// -----------------------------------------------------------------------------
// dvbc_deinterleaver
//
// Convolutional (Forney) byte deinterleaver for DVB-C, I=12 branches with a
// FIFO unit depth of M=17 bytes. It is the receive-side inverse of
// dvbc_interleaver. It sits between the QAM demapper/byte packer and the
// RS(204,188) decoder.
//
// Branch j (0..I-2) delays its bytes by (I-1-j)*M visits of the commutator.
// Branch I-1 passes bytes straight through. Interleaver plus deinterleaver
// therefore give a constant end-to-end delay of I*(I-1)*M = 2244 bytes.
//
// All branch FIFOs share one RAM of M*I*(I-1)/2 words of {sync,data}. Each
// branch owns a contiguous window of that RAM and a private circular pointer.
// An accept reads the oldest word of the current branch and overwrites it with
// the incoming byte (read-before-write). The read word lands in the output
// register on the following clock.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_data    in   DW  interleaved byte
//   in_sync    in   1   in_data is a packet sync byte (marks branch 0)
//   in_valid   in   1   in_data/in_sync valid
//   in_ready   out  1   byte accepted when in_valid && in_ready
//   out_data   out  DW  deinterleaved byte (0 until primed)
//   out_sync   out  1   out_data is the sync byte of a 204-byte packet
//   out_valid  out  1   output register holds a byte
//   out_ready  in   1   downstream takes byte when out_valid && out_ready
//   out_primed out  1   delay line filled, output data meaningful (sticky)
//   sync_err   out  1   one-cycle pulse, in_sync accepted off branch 0
//
// Configuration macro
//   DVBC_DEINT_SYNC_ALIGN_EN
//     Defined:   a misaligned in_sync forces that byte onto branch 0 and
//                restarts priming. Branch pointers are kept, so the delay
//                line simply refills.
//     Undefined: the commutator free-runs from reset. A misaligned in_sync
//                only raises sync_err.
// -----------------------------------------------------------------------------
module dvbc_deinterleaver #(
    parameter int I  = 12,
    parameter int M  = 17,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_sync,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sync,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_primed,
    output logic          sync_err
);

    localparam int RAM_WORDS = M * I * (I - 1) / 2;
    localparam int FILL_MAX  = I * (I - 1) * M;
    localparam int AW        = $clog2(RAM_WORDS);
    localparam int BW        = $clog2(I);
    localparam int PW        = $clog2((I - 1) * M);
    localparam int FW        = $clog2(FILL_MAX + 1);
    localparam int WW        = DW + 1;

    localparam logic [BW-1:0] LAST_B = BW'(I - 1);

    // First RAM word owned by branch j.
    function automatic int branch_base(input int j);
        int s;
        s = 0;
        for (int k = 0; k < j; k++) begin
            s += (I - 1 - k) * M;
        end
        return s;
    endfunction

    // Number of words in branch j's circular buffer.
    function automatic int branch_depth(input int j);
        return (I - 1 - j) * M;
    endfunction

    // Commutator and fill state
    logic [BW-1:0] b;
    logic [PW-1:0] ptr [I-1];
    logic [FW-1:0] fill;

    // Accept-path decode
    logic          accept;
    logic          misalign;
    logic          realign;
    logic [BW-1:0] b_eff;
    logic [PW-1:0] cur_ptr;
    logic [AW-1:0] cur_base;
    logic [AW-1:0] ram_addr;
    logic          ram_we;

    // Storage and output staging
    logic [WW-1:0] ram [RAM_WORDS];
    logic [WW-1:0] ram_q;
    logic [WW-1:0] pass_q;
    logic          sel_pass;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign misalign = accept && in_sync && (b != '0);

`ifdef DVBC_DEINT_SYNC_ALIGN_EN
    // A sync byte seen off branch 0 re-anchors the commutator on this byte.
    assign realign = misalign;
`else
    assign realign = 1'b0;
`endif

    // Branch actually serviced by the current byte.
    assign b_eff = realign ? '0 : b;

    // The last branch has no storage. Its byte bypasses the RAM.
    assign ram_we = accept && (b_eff != LAST_B);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no
        // path through the block can leave it unassigned and infer a latch.
        cur_ptr  = '0;
        cur_base = '0;
        for (int j = 0; j < I - 1; j++) begin
            if (b_eff == BW'(j)) begin
                cur_ptr  = ptr[j];
                cur_base = AW'(branch_base(j));
            end
        end
    end

    assign ram_addr = cur_base + AW'(cur_ptr);

    // NOTE: the RAM has no reset. A RAM array cannot be cleared in one cycle,
    // so stale words are masked by out_primed instead.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q          <= ram[ram_addr];
            ram[ram_addr]  <= {in_sync, in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b          <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_primed <= 1'b0;
            sync_err   <= 1'b0;
            sel_pass   <= 1'b0;
            pass_q     <= '0;
            for (int j = 0; j < I - 1; j++) begin
                ptr[j] <= '0;
            end
        end else begin
            sync_err <= misalign;

            if (accept) begin
                for (int j = 0; j < I - 1; j++) begin
                    if (b_eff == BW'(j)) begin
                        ptr[j] <= (ptr[j] == PW'(branch_depth(j) - 1)) ? '0
                                                                      : ptr[j] + PW'(1);
                    end
                end

                b <= (b_eff == LAST_B) ? '0 : b_eff + BW'(1);

                // The realigning byte is itself the first byte of the new fill.
                if (realign) begin
                    fill       <= FW'(1);
                    out_primed <= 1'b0;
                end else begin
                    if (fill != FW'(FILL_MAX)) begin
                        fill <= fill + FW'(1);
                    end
                    if (fill == FW'(FILL_MAX - 1)) begin
                        out_primed <= 1'b1;
                    end
                end

                out_valid <= 1'b1;
                sel_pass  <= (b_eff == LAST_B);
                if (b_eff == LAST_B) begin
                    pass_q <= {in_sync, in_data};
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Output word comes from the RAM read register or the bypass register.
    // It is forced to zero until the delay line holds real data. All sources
    // change only on an accept, so the word holds steady under backpressure.
    assign out_data = out_primed ? (sel_pass ? pass_q[DW-1:0] : ram_q[DW-1:0]) : '0;
    assign out_sync = out_primed && (sel_pass ? pass_q[DW] : ram_q[DW]);

endmodule

// File: tb/tb_dvbc_deinterleaver.sv
// -----------------------------------------------------------------------------
// tb_dvbc_deinterleaver
//
// Directed bench for dvbc_deinterleaver. A behavioural DVB-C interleaver feeds
// the DUT with a packet stream. Its branch FIFOs start zeroed.
//
// For every accepted byte, the expected output word is pushed to a
// scoreboard. That word is the source byte 2244 positions earlier, or zero
// while the delay line is still filling. Entries are popped and compared when
// the DUT hands a byte downstream.
//
// The bench also checks the following every cycle:
//   - the in_ready rule,
//   - sync_err,
//   - output stability while stalled.
//
// DVBC_DEINT_SYNC_ALIGN_EN selects the matching misaligned-sync scenario.
// -----------------------------------------------------------------------------
module tb_dvbc_deinterleaver;

    localparam int NB    = 12;
    localparam int MU    = 17;
    localparam int DELAY = NB * (NB - 1) * MU;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sync;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_sync;
    logic       out_valid;
    logic       out_ready;
    logic       out_primed;
    logic       sync_err;

    always #5 clk = ~clk;

    dvbc_deinterleaver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sync   (out_sync),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_primed (out_primed),
        .sync_err   (sync_err)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard of {primed, sync, data}
    logic [9:0] exp_q [$];

    // Behavioural interleaver (branch j delays by j*MU visits)
    logic [8:0] il_mem [NB][(NB-1)*MU];
    int         il_ptr [NB];
    int         src_idx;
    logic [8:0] cur_word;

    // Reference bookkeeping
    int         n_acc;
    int         tb_b;
    int         sync_override_idx;
    logic       exp_sync_err;
    logic       prev_stall;
    logic [9:0] prev_out;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Source packets: 0x47 sync byte followed by 203 incrementing bytes.
    function automatic logic [8:0] src_word(input int k);
        int pos;
        pos = k % 204;
        if (pos == 0) return {1'b1, 8'h47};
        return {1'b0, 8'((k / 204) * 7 + pos)};
    endfunction

    task automatic il_advance();
        int         j;
        logic [8:0] w;
        j = src_idx % NB;
        w = src_word(src_idx);
        if (j == 0) begin
            cur_word = w;
        end else begin
            cur_word              = il_mem[j][il_ptr[j]];
            il_mem[j][il_ptr[j]]  = w;
            il_ptr[j]             = (il_ptr[j] == j * MU - 1) ? 0 : il_ptr[j] + 1;
        end
        src_idx++;
    endtask

    task automatic il_restart();
        for (int j = 0; j < NB; j++) begin
            il_ptr[j] = 0;
            for (int k = 0; k < (NB - 1) * MU; k++) il_mem[j][k] = '0;
        end
        src_idx = 0;
        il_advance();
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, end on the next
    // falling edge.
    task automatic step(input bit v, input logic [8:0] w, input bit rdy, output bit acc);
        logic [9:0] e;
        bit         realign;
        in_valid  = v;
        in_sync   = w[8];
        in_data   = w[7:0];
        out_ready = rdy;
        #1;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        check("sync_err", sync_err, exp_sync_err);
        if (prev_stall) check("stall_hold", {out_primed, out_sync, out_data}, prev_out);
        if (out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_word", {out_primed, out_sync, out_data}, e);
            end
        end
        acc          = v && in_ready;
        exp_sync_err = acc && w[8] && (tb_b != 0);
        prev_stall   = out_valid && !out_ready;
        prev_out     = {out_primed, out_sync, out_data};
        if (acc) begin
            realign = 1'b0;
`ifdef DVBC_DEINT_SYNC_ALIGN_EN
            realign = w[8] && (tb_b != 0);
`endif
            if (realign) begin
                n_acc = 0;
                tb_b  = 0;
            end
            e[8:0] = (n_acc >= DELAY) ? src_word(n_acc - DELAY) : 9'h000;
            if (n_acc == sync_override_idx) e[8] = 1'b1;
            e[9] = (n_acc + 1 >= DELAY);
            exp_q.push_back(e);
            n_acc++;
            tb_b = (tb_b + 1) % NB;
        end
        @(negedge clk);
    endtask

    task automatic run_stream(input int count, input int ready_pct, input int valid_pct);
        int done;
        int cyc;
        bit acc;
        bit v;
        bit r;
        done = 0;
        cyc  = 0;
        while (done < count && cyc < count * 8 + 100) begin
            v = ($urandom_range(99) < valid_pct);
            r = ($urandom_range(99) < ready_pct);
            step(v, cur_word, r, acc);
            if (acc) begin
                done++;
                il_advance();
            end
            cyc++;
        end
        check("stream_budget", done, count);
    endtask

    task automatic run_until_branch(input int target);
        int guard;
        guard = 0;
        while (tb_b != target && guard < 2 * NB) begin
            run_stream(1, 100, 100);
            guard++;
        end
        check("branch_reached", tb_b, target);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_sync", out_sync, 1'b0);
        check("rst_out_primed", out_primed, 1'b0);
        check("rst_sync_err", sync_err, 1'b0);
        exp_q.delete();
        prev_stall        = 1'b0;
        exp_sync_err      = 1'b0;
        tb_b              = 0;
        n_acc             = 0;
        sync_override_idx = -1;
        @(negedge clk);
        rst_n = 1'b1;
        il_restart();
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        bit         acc;
        logic [8:0] w11;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Loopback at full rate: primed after DELAY accepts, source delayed by DELAY.
        run_stream(DELAY - 1, 100, 100);
        check("t1_not_primed", out_primed, 1'b0);
        run_stream(1, 100, 100);
        check("t1_primed", out_primed, 1'b1);
        run_stream(20 * 204 - DELAY, 100, 100);

        // Pass-through branch: the byte appears one clock after its accept.
        run_until_branch(NB - 1);
        step(1'b0, cur_word, 1'b1, acc);
        w11 = cur_word;
        step(1'b1, w11, 1'b1, acc);
        check("t3_accept", acc, 1'b1);
        il_advance();
        check("t3_b11_valid", out_valid, 1'b1);
        check("t3_b11_word", {out_sync, out_data}, w11);

        // Random backpressure on a continuous input stream.
        run_stream(3000, 50, 100);

        // Reset mid-operation, then again at byte 1000 of the fresh stream.
        do_reset();
        run_stream(1000, 100, 100);
        do_reset();
        run_stream(DELAY - 1, 70, 90);
        check("t4_not_primed", out_primed, 1'b0);
        run_stream(1, 100, 100);
        check("t4_primed", out_primed, 1'b1);
        run_stream(800, 50, 90);

        // Misaligned sync on branch 5.
        run_until_branch(5);
`ifdef DVBC_DEINT_SYNC_ALIGN_EN
        il_restart();
        step(1'b1, cur_word, 1'b1, acc);
        check("t5_accept", acc, 1'b1);
        il_advance();
        check("t5_sync_err_pulse", sync_err, 1'b1);
        check("t5_primed_cleared", out_primed, 1'b0);
        step(1'b0, cur_word, 1'b1, acc);
        check("t5_sync_err_end", sync_err, 1'b0);
        run_stream(DELAY - 1, 100, 100);
        check("t5_primed_again", out_primed, 1'b1);
        run_stream(400, 50, 90);
`else
        sync_override_idx = n_acc + NB * MU * (NB - 1 - 5);
        step(1'b1, {1'b1, cur_word[7:0]}, 1'b1, acc);
        check("t5_accept", acc, 1'b1);
        il_advance();
        check("t5_sync_err_pulse", sync_err, 1'b1);
        check("t5_primed_kept", out_primed, 1'b1);
        step(1'b0, cur_word, 1'b1, acc);
        check("t5_sync_err_end", sync_err, 1'b0);
        run_stream(NB * MU * (NB - 1 - 5) + 200, 60, 90);
`endif

        // Drain and confirm every expected byte came out.
        for (int i = 0; i < 3; i++) step(1'b0, cur_word, 1'b1, acc);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
